seq_reader_ram16x4: RTL

- Read-side sequencer for the team's synchronous 16x4 RAM, which has a registered address and one-cycle read latency.
- On start, it walks addresses from START_ADDR to a sampled last address, fetching each 4-bit word (drone move code, one-hot).
- Each word is presented downstream on a valid/ready handshake.
- Sits between the game/drone FSM (consumer) and the RAM. It never writes: mem_we is tied 0.

---
 rtl/seq_reader_ram16x4_pkg.sv | 16 +
 rtl/seq_reader_ram16x4_counter.sv | 35 +++
 rtl/seq_reader_ram16x4.sv | 95 +++++++++
 3 files changed

// File: rtl/seq_reader_ram16x4_pkg.sv
// Shared types for the 16x4 RAM read sequencer.
// State encodings and default RAM geometry.
package seq_reader_ram16x4_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_PRESENT = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

endpackage

// File: rtl/seq_reader_ram16x4_counter.sv
// Loadable wrap-around address pointer with latched last address.
// Ports: clk, reset_n, load, inc, last_in -> ptr, eq_last.
module seq_addr_counter
  import seq_reader_ram16x4_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] last_in,
  output logic [ADDR_W-1:0] ptr,
  output logic              eq_last
);

  logic [ADDR_W-1:0] last_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr    <= START_ADDR;
      last_q <= '0;
    end else if (load) begin
      ptr    <= START_ADDR;
      last_q <= last_in;
    end else if (inc) begin
      // Natural overflow gives the 15 -> 0 wrap.
      ptr <= ptr + 1'b1;
    end
  end

  assign eq_last = (ptr == last_q);

endmodule

// File: rtl/seq_reader_ram16x4.sv
// Walks RAM from START_ADDR to a latched last address, presenting
// each word on cmd_valid/cmd_ready. Read-only: mem_we is tied low.
module seq_reader_ram16x4
  import seq_reader_ram16x4_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                DATA_W     = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] cmd_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] index,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              eq_last;
  logic              hs;
  logic              load;
  logic              inc;

  assign hs   = (state == S_PRESENT) && cmd_valid && cmd_ready;
  assign load = (state == S_IDLE) && start && !abort;
  assign inc  = hs && !eq_last && !abort;

  seq_addr_counter #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .inc     (inc),
    .last_in (last_addr),
    .ptr     (ptr),
    .eq_last (eq_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cmd_data  <= '0;
      cmd_valid <= 1'b0;
      index     <= '0;
    end else if (abort) begin
      // Word data/index hold; only the handshake is withdrawn.
      state     <= S_IDLE;
      cmd_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          cmd_data  <= mem_q;
          index     <= ptr;
          cmd_valid <= 1'b1;
          state     <= S_PRESENT;
        end
        S_PRESENT: begin
          if (hs) begin
            cmd_valid <= 1'b0;
            state     <= eq_last ? S_FINISH : S_FETCH;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr = ptr;
  assign mem_we   = 1'b0;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_FINISH);

endmodule
